// File: rtl/counter_share_arbiter_if.sv
// counter_share_arbiter_if
//   Bus between NREQ requesters and the shared interval counter.
//   Ports (signals):
//     req       NREQ     request vector, held by requester i until done[i]
//     req_term  NREQ*CW  terminal counts, requester i at [i*CW +: CW]
//     gnt       NREQ     one-hot registered grant
//     done      NREQ     one-hot one-cycle completion pulse
//     cnt       CW       current count of the shared counter
//     busy      1        arbiter not idle
//   Modports: master = requester side, slave = arbiter side.
interface counter_share_arbiter_if #(
    parameter int NREQ = 2,
    parameter int CW   = 6
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] req_term;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      cnt;
    logic               busy;

    modport master (
        output req, req_term,
        input  gnt, done, cnt, busy
    );

    modport slave (
        input  req, req_term,
        output gnt, done, cnt, busy
    );
endinterface

// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter
//   Shares one CW-bit interval counter between NREQ requesters. Round-robin
//   grant, loads the winner's terminal count, counts 0..term, pulses done to
//   the winner, then returns to IDLE for one cycle before re-arbitrating.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    counter_share_arbiter_if.slave (req, req_term, gnt, done, cnt, busy)
//     pause  only when CNT_ARB_PAUSE_EN is defined; 1 in RUN freezes the
//            counter and suppresses the terminal compare
//   Config macro: CNT_ARB_PAUSE_EN (undefined by default -> no pause port).
module counter_share_arbiter #(
    parameter int NREQ = 2,
    parameter int CW   = 6
) (
    input  logic clk,
    input  logic reset,
    counter_share_arbiter_if.slave bus
`ifdef CNT_ARB_PAUSE_EN
    ,
    input  logic pause
`endif
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   term_q, term_d;
    logic [IW-1:0]   w_q, w_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;

    logic [IW-1:0]   win;
    logic            any;
    logic            paused;
    logic [IW-1:0]   rr_after_w;

`ifdef CNT_ARB_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // Pointer handed to the next arbitration: one past the current owner.
    assign rr_after_w = (w_q == IW'(NREQ-1)) ? '0 : w_q + 1'b1;

    // Round-robin pick: scan offsets from high to low so the smallest offset
    // from rr_q is the last (winning) assignment.
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        any = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req[IW'(idx)]) begin
                win = IW'(idx);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        term_d  = term_q;
        w_d     = w_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                cnt_d = '0;
                if (any) begin
                    state_d    = RUN;
                    w_d        = win;
                    gnt_d[win] = 1'b1;
                    term_d     = bus.req_term[int'(win)*CW +: CW];
                end
            end
            RUN: begin
                // Abort beats the terminal compare and pause.
                if (!bus.req[w_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    rr_d    = rr_after_w;
                end else if (paused) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == term_q) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                rr_d    = rr_after_w;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            term_q  <= '0;
            w_q     <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
            w_q     <= w_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.cnt  = cnt_q;
    assign bus.busy = (state_q != IDLE);
endmodule
